// File: rtl/axi_lite_reg_slave.sv
// ============================================================================
// Module      : axi_lite_reg_slave
// Description : AXI-Lite responder over a bank of 32-bit registers, with a
//               flattened hardware view, write notification and hw update port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_lite_reg_slave #(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            aw_addr,
    input  logic [2:0]             aw_prot,
    input  logic                   aw_valid,
    output logic                   aw_ready,
    input  logic [31:0]            w_data,
    input  logic [3:0]             w_strb,
    input  logic                   w_valid,
    output logic                   w_ready,
    output logic [1:0]             b_resp,
    output logic                   b_valid,
    input  logic                   b_ready,
    input  logic [31:0]            ar_addr,
    input  logic [2:0]             ar_prot,
    input  logic                   ar_valid,
    output logic                   ar_ready,
    output logic [31:0]            r_data,
    output logic [1:0]             r_resp,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [32*NUM_REGS-1:0] regs_o,
    output logic                   wr_pulse_o,
    output logic [IDX_W-1:0]       wr_idx_o,
    input  logic                   hw_we_i,
    input  logic [IDX_W-1:0]       hw_idx_i,
    input  logic [31:0]            hw_data_i
);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam logic [0:0] c_W_IDLE = 1'b0;
    localparam logic [0:0] c_W_RESP = 1'b1;
    localparam logic [0:0] c_R_IDLE = 1'b0;
    localparam logic [0:0] c_R_DATA = 1'b1;

    logic [0:0]       r_wstate, w_wstate_nxt;
    logic [0:0]       r_rstate, w_rstate_nxt;
    logic [31:0]      r_regs [NUM_REGS];

    logic             r_aw_held, r_w_held;
    logic [31:0]      r_aw_addr, r_w_data;
    logic [3:0]       r_w_strb;
    logic             r_aw_ready, r_w_ready, r_b_valid;
    logic [1:0]       r_b_resp;
    logic             r_wr_pulse;
    logic [IDX_W-1:0] r_wr_idx;
    logic             r_ar_ready, r_r_valid;
    logic [31:0]      r_r_data;
    logic [1:0]       r_r_resp;

    logic             w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic             w_commit;
    logic [32:0]      w_wr_diff, w_rd_diff;
    logic             w_wr_ok, w_rd_ok;
    logic [IDX_W-1:0] w_wr_idx, w_rd_idx;
    logic             w_unused_ok;

    assign w_aw_hs = aw_valid & r_aw_ready;
    assign w_w_hs  = w_valid & r_w_ready;
    assign w_b_hs  = r_b_valid & b_ready;
    assign w_ar_hs = ar_valid & r_ar_ready;
    assign w_r_hs  = r_r_valid & r_ready;

    // Bit 32 of the difference is the borrow: set when the address lies below BASE_ADDR.
    assign w_wr_diff = {1'b0, r_aw_addr} - {1'b0, BASE_ADDR};
    assign w_rd_diff = {1'b0, ar_addr} - {1'b0, BASE_ADDR};
    assign w_wr_ok   = ~w_wr_diff[32] && (w_wr_diff[31:2] < 30'(NUM_REGS));
    assign w_rd_ok   = ~w_rd_diff[32] && (w_rd_diff[31:2] < 30'(NUM_REGS));
    assign w_wr_idx  = w_wr_diff[IDX_W+1:2];
    assign w_rd_idx  = w_rd_diff[IDX_W+1:2];

    assign w_commit = (r_wstate == c_W_IDLE) & r_aw_held & r_w_held;

    assign w_unused_ok = ^{aw_prot, ar_prot, w_wr_diff[1:0], w_rd_diff[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= c_W_IDLE;
            r_rstate <= c_R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_rstate_nxt = r_rstate;
        case (r_wstate)
            c_W_IDLE: if (w_commit) w_wstate_nxt = c_W_RESP;
            default:  if (w_b_hs)   w_wstate_nxt = c_W_IDLE;
        endcase
        case (r_rstate)
            c_R_IDLE: if (w_ar_hs) w_rstate_nxt = c_R_DATA;
            default:  if (w_r_hs)  w_rstate_nxt = c_R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_addr  <= '0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_aw_ready <= 1'b0;
            r_w_ready  <= 1'b0;
            r_b_valid  <= 1'b0;
            r_b_resp   <= c_RESP_OKAY;
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
        end else begin
            r_wr_pulse <= 1'b0;
            case (r_wstate)
                c_W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_aw_addr <= aw_addr;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_w_data <= w_data;
                        r_w_strb <= w_strb;
                    end
                    r_aw_ready <= ~(r_aw_held | w_aw_hs);
                    r_w_ready  <= ~(r_w_held | w_w_hs);
                    if (w_commit) begin
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        r_aw_ready <= 1'b0;
                        r_w_ready  <= 1'b0;
                        r_b_valid  <= 1'b1;
                        r_b_resp   <= w_wr_ok ? c_RESP_OKAY : c_RESP_SLVERR;
                        if (w_wr_ok) begin
                            r_wr_pulse <= 1'b1;
                            r_wr_idx   <= w_wr_idx;
                        end
                    end
                end
                default: begin
                    if (w_b_hs) begin
                        r_b_valid  <= 1'b0;
                        r_aw_ready <= 1'b1;
                        r_w_ready  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // AXI bytes take priority over a same-cycle hw write; other hw bytes still land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (w_commit && w_wr_ok && (w_wr_idx == IDX_W'(i)) && r_w_strb[k]) begin
                        r_regs[i][8*k +: 8] <= r_w_data[8*k +: 8];
                    end else if (hw_we_i && (hw_idx_i == IDX_W'(i))) begin
                        r_regs[i][8*k +: 8] <= hw_data_i[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ar_ready <= 1'b0;
            r_r_valid  <= 1'b0;
            r_r_data   <= '0;
            r_r_resp   <= c_RESP_OKAY;
        end else begin
            case (r_rstate)
                c_R_IDLE: begin
                    if (w_ar_hs) begin
                        r_ar_ready <= 1'b0;
                        r_r_valid  <= 1'b1;
                        r_r_data   <= w_rd_ok ? r_regs[w_rd_idx] : 32'h0;
                        r_r_resp   <= w_rd_ok ? c_RESP_OKAY : c_RESP_SLVERR;
                    end else begin
                        r_ar_ready <= 1'b1;
                    end
                end
                default: begin
                    if (w_r_hs) begin
                        r_r_valid  <= 1'b0;
                        r_ar_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_flat
            assign regs_o[32*gi +: 32] = r_regs[gi];
        end
    endgenerate

    assign aw_ready   = r_aw_ready;
    assign w_ready    = r_w_ready;
    assign b_valid    = r_b_valid;
    assign b_resp     = r_b_resp;
    assign ar_ready   = r_ar_ready;
    assign r_valid    = r_r_valid;
    assign r_data     = r_r_data;
    assign r_resp     = r_r_resp;
    assign wr_pulse_o = r_wr_pulse;
    assign wr_idx_o   = r_wr_idx;

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
// ============================================================================
// Module      : tb_axi_lite_reg_slave
// Description : Scenario bench for axi_lite_reg_slave with B/R response queues.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_lite_reg_slave;

    localparam int          c_NUM  = 16;
    localparam int          c_IW   = 4;
    localparam logic [31:0] c_BASE = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       aw_addr = '0;
    logic [2:0]        aw_prot = '0;
    logic              aw_valid = 1'b0;
    logic              aw_ready;
    logic [31:0]       w_data = '0;
    logic [3:0]        w_strb = '0;
    logic              w_valid = 1'b0;
    logic              w_ready;
    logic [1:0]        b_resp;
    logic              b_valid;
    logic              b_ready = 1'b0;
    logic [31:0]       ar_addr = '0;
    logic [2:0]        ar_prot = '0;
    logic              ar_valid = 1'b0;
    logic              ar_ready;
    logic [31:0]       r_data;
    logic [1:0]        r_resp;
    logic              r_valid;
    logic              r_ready = 1'b0;
    logic [32*c_NUM-1:0] regs_o;
    logic              wr_pulse_o;
    logic [c_IW-1:0]   wr_idx_o;
    logic              hw_we_i = 1'b0;
    logic [c_IW-1:0]   hw_idx_i = '0;
    logic [31:0]       hw_data_i = '0;

    int n_vec = 0;
    int n_mis = 0;
    logic [1:0]          b_q [$];
    logic [33:0]         r_q [$];
    logic [32*c_NUM-1:0] exp_regs = '0;

    axi_lite_reg_slave #(.NUM_REGS(c_NUM), .BASE_ADDR(c_BASE), .IDX_W(c_IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .wr_idx_o(wr_idx_o),
        .hw_we_i(hw_we_i), .hw_idx_i(hw_idx_i), .hw_data_i(hw_data_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] reg_at(input int i);
        return regs_o[32*i +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responses are scored at the negedge preceding their handshake edge.
    logic [1:0]  mon_b;
    logic [33:0] mon_r;
    always @(negedge clk) begin
        if (rst_n && b_valid && b_ready) begin
            n_vec++;
            if (b_q.size() == 0) begin
                n_mis++;
                $display("FAIL b_unexpected: got b_resp %b, none expected", b_resp);
            end else begin
                mon_b = b_q.pop_front();
                if (b_resp !== mon_b) begin
                    n_mis++;
                    $display("FAIL b_resp: got %b want %b", b_resp, mon_b);
                end
            end
        end
        if (rst_n && r_valid && r_ready) begin
            n_vec++;
            if (r_q.size() == 0) begin
                n_mis++;
                $display("FAIL r_unexpected: got %h/%b, none expected", r_data, r_resp);
            end else begin
                mon_r = r_q.pop_front();
                if ({r_data, r_resp} !== mon_r) begin
                    n_mis++;
                    $display("FAIL r_beat: got %h/%b want %h/%b", r_data, r_resp, mon_r[33:2], mon_r[1:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, r_data, wr_pulse_o, wr_idx_o} !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: got aw%b w%b ar%b b%b r%b data %h", aw_ready, w_ready, ar_ready, b_valid, r_valid, r_data);
        end
        n_vec++;
        if (regs_o !== '0) begin
            n_mis++;
            $display("FAIL reset_regs: got %h want 0", regs_o);
        end
        rst_n = 1'b1;
        #2;
        n_vec++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b000) begin
            n_mis++;
            $display("FAIL ready_before_edge: got %b want 000", {aw_ready, w_ready, ar_ready});
        end
        tick();
        n_vec++;
        if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
            n_mis++;
            $display("FAIL ready_after_edge: got %b want 111", {aw_ready, w_ready, ar_ready});
        end
    endtask

    task automatic test_write_same_cycle();
        aw_addr = c_BASE + 32'h8; aw_valid = 1'b1;
        w_data = 32'hDEAD_BEEF; w_strb = 4'hF; w_valid = 1'b1;
        b_q.push_back(2'b00);
        exp_regs[32*2 +: 32] = 32'hDEAD_BEEF;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        n_vec++;
        if ({aw_ready, w_ready, b_valid} !== 3'b000) begin
            n_mis++;
            $display("FAIL same_cycle_capture: got aw%b w%b b%b want 000", aw_ready, w_ready, b_valid);
        end
        tick();
        n_vec++;
        if ({b_valid, wr_pulse_o, wr_idx_o} !== {1'b1, 1'b1, 4'd2} || reg_at(2) !== 32'hDEAD_BEEF) begin
            n_mis++;
            $display("FAIL same_cycle_commit: got b%b pulse%b idx%0d reg2 %h want 1 1 2 deadbeef", b_valid, wr_pulse_o, wr_idx_o, reg_at(2));
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        n_vec++;
        if ({b_valid, wr_pulse_o, aw_ready, w_ready} !== 4'b0011) begin
            n_mis++;
            $display("FAIL same_cycle_bdone: got b%b pulse%b aw%b w%b want 0 0 1 1", b_valid, wr_pulse_o, aw_ready, w_ready);
        end
    endtask

    task automatic test_w_first_backpressure();
        hw_we_i = 1'b1; hw_idx_i = 4'd1; hw_data_i = 32'hFFFF_FFFF;
        tick();
        hw_we_i = 1'b0;
        n_vec++;
        if (reg_at(1) !== 32'hFFFF_FFFF || wr_pulse_o !== 1'b0) begin
            n_mis++;
            $display("FAIL hw_preset: got reg1 %h pulse %b want ffffffff 0", reg_at(1), wr_pulse_o);
        end
        w_data = 32'h1234_5678; w_strb = 4'b0101; w_valid = 1'b1;
        tick();
        w_valid = 1'b0;
        n_vec++;
        if ({w_ready, aw_ready} !== 2'b01) begin
            n_mis++;
            $display("FAIL w_first_ready: got w%b aw%b want 0 1", w_ready, aw_ready);
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if (b_valid !== 1'b0) begin
                n_mis++;
                $display("FAIL w_first_no_b: got b_valid %b want 0", b_valid);
            end
        end
        aw_addr = c_BASE + 32'h4; aw_valid = 1'b1;
        b_q.push_back(2'b00);
        exp_regs[32*1 +: 32] = 32'hFF34_FF78;
        tick();
        aw_valid = 1'b0;
        n_vec++;
        if (b_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL w_first_b_early: got b_valid %b want 0", b_valid);
        end
        tick();
        n_vec++;
        if (b_valid !== 1'b1 || reg_at(1) !== 32'hFF34_FF78 || wr_idx_o !== 4'd1) begin
            n_mis++;
            $display("FAIL w_first_commit: got b%b reg1 %h idx%0d want 1 ff34ff78 1", b_valid, reg_at(1), wr_idx_o);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_vec++;
            if ({b_valid, b_resp, aw_ready, w_ready} !== 5'b10000) begin
                n_mis++;
                $display("FAIL b_hold: got b%b resp%b aw%b w%b want 1 00 0 0", b_valid, b_resp, aw_ready, w_ready);
            end
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
    endtask

    task automatic test_read_backpressure();
        ar_addr = c_BASE + 32'h8; ar_valid = 1'b1;
        r_q.push_back({32'hDEAD_BEEF, 2'b00});
        tick();
        ar_valid = 1'b0;
        n_vec++;
        if ({r_valid, ar_ready} !== 2'b10 || r_data !== 32'hDEAD_BEEF) begin
            n_mis++;
            $display("FAIL read_first: got rv%b ar%b data %h want 1 0 deadbeef", r_valid, ar_ready, r_data);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if ({r_valid, r_resp} !== 3'b100 || r_data !== 32'hDEAD_BEEF) begin
                n_mis++;
                $display("FAIL r_hold: got rv%b resp%b data %h want 1 00 deadbeef", r_valid, r_resp, r_data);
            end
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        n_vec++;
        if ({r_valid, ar_ready} !== 2'b01) begin
            n_mis++;
            $display("FAIL read_done: got rv%b ar%b want 0 1", r_valid, ar_ready);
        end
    endtask

    task automatic test_out_of_range();
        aw_addr = c_BASE + 32'(4 * c_NUM); aw_valid = 1'b1;
        w_data = 32'hCAFE_F00D; w_strb = 4'hF; w_valid = 1'b1;
        b_q.push_back(2'b10);
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        tick();
        n_vec++;
        if ({b_valid, wr_pulse_o} !== 2'b10 || regs_o !== exp_regs) begin
            n_mis++;
            $display("FAIL oor_write: got b%b pulse%b regs %h want 1 0 %h", b_valid, wr_pulse_o, regs_o, exp_regs);
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        ar_addr = c_BASE + 32'(4 * c_NUM); ar_valid = 1'b1;
        r_q.push_back({32'h0, 2'b10});
        tick();
        ar_valid = 1'b0;
        n_vec++;
        if (r_valid !== 1'b1) begin
            n_mis++;
            $display("FAIL oor_read_valid: got %b want 1", r_valid);
        end
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        hw_we_i = 1'b1; hw_idx_i = 4'd3; hw_data_i = 32'h0BAD_F00D;
        tick();
        hw_we_i = 1'b0;
        aw_addr = c_BASE + 32'hC; aw_valid = 1'b1;
        w_data = 32'hAAAA_AAAA; w_strb = 4'b0011; w_valid = 1'b1;
        b_q.push_back(2'b00);
        tick();
        aw_valid = 1'b0; w_valid = 1'b0;
        hw_we_i = 1'b1; hw_idx_i = 4'd3; hw_data_i = 32'h5555_5555;
        ar_addr = c_BASE + 32'hC; ar_valid = 1'b1;
        r_q.push_back({32'h0BAD_F00D, 2'b00});
        exp_regs[32*3 +: 32] = 32'h5555_AAAA;
        tick();
        hw_we_i = 1'b0; ar_valid = 1'b0;
        n_vec++;
        if (regs_o !== exp_regs || {wr_pulse_o, wr_idx_o, b_valid, r_valid} !== {1'b1, 4'd3, 1'b1, 1'b1}) begin
            n_mis++;
            $display("FAIL same_edge: got reg3 %h pulse%b idx%0d b%b r%b want 5555aaaa 1 3 1 1", reg_at(3), wr_pulse_o, wr_idx_o, b_valid, r_valid);
        end
        b_ready = 1'b1; r_ready = 1'b1;
        tick();
        b_ready = 1'b0; r_ready = 1'b0;
        n_vec++;
        if ({b_valid, r_valid} !== 2'b00) begin
            n_mis++;
            $display("FAIL same_edge_done: got b%b r%b want 0 0", b_valid, r_valid);
        end
    endtask

    task automatic test_async_reset();
        aw_addr = c_BASE; aw_valid = 1'b1;
        w_data = 32'h1111_1111; w_strb = 4'hF; w_valid = 1'b1;
        ar_addr = c_BASE + 32'h4; ar_valid = 1'b1;
        tick();
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        tick();
        n_vec++;
        if ({b_valid, r_valid} !== 2'b11) begin
            n_mis++;
            $display("FAIL pre_abort: got b%b r%b want 1 1", b_valid, r_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp, r_data, wr_pulse_o, wr_idx_o} !== '0 || regs_o !== '0) begin
            n_mis++;
            $display("FAIL async_reset: got b%b r%b data %h idx%0d regs %h want all 0", b_valid, r_valid, r_data, wr_idx_o, regs_o);
        end
        exp_regs = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        n_vec++;
        if ({aw_ready, w_ready, ar_ready, b_valid, r_valid} !== 5'b11100) begin
            n_mis++;
            $display("FAIL post_abort: got %b want 11100", {aw_ready, w_ready, ar_ready, b_valid, r_valid});
        end
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_first_backpressure();
        test_read_backpressure();
        test_out_of_range();
        test_simultaneous();
        test_async_reset();
        n_vec++;
        if (b_q.size() != 0 || r_q.size() != 0) begin
            n_mis++;
            $display("FAIL queues_drained: got %0d B and %0d R pending want 0", b_q.size(), r_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
